alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 94 +++++++++
 tb/tb_alu_result_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind the ALU result selector.
// Flags are computed once at capture so the consumer sees them with the data.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int SELW  = 4,
  parameter int NSRC  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_selerr,
  output logic [1:0]       count,
  output logic [7:0]       err_count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  sel;
    logic             zero;
    logic             neg;
    logic             selerr;
  } entry_t;

  // One extra bit so NSRC == 2**SELW still compares correctly.
  localparam logic [SELW:0] LP_NSRC = (SELW+1)'(NSRC);

  entry_t      r_slot0;
  entry_t      r_slot1;
  logic [1:0]  r_count;
  logic [7:0]  r_err_count;

  entry_t      w_new;
  entry_t      w_head;
  logic        w_push;
  logic        w_pop;

  always_comb begin
    w_new        = '0;
    w_new.data   = in_data;
    w_new.sel    = in_sel;
    w_new.zero   = (in_data == '0);
    w_new.neg    = in_data[WIDTH-1];
    w_new.selerr = ({1'b0, in_sel} >= LP_NSRC);
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot0     <= '0;
      r_slot1     <= '0;
      r_count     <= 2'd0;
      r_err_count <= 8'd0;
    end else begin
      // Push and pop together can only happen at count 1: the new entry becomes head.
      if (w_push && w_pop) begin
        r_slot0 <= w_new;
      end else if (w_push) begin
        if (r_count == 2'd0) r_slot0 <= w_new;
        else                 r_slot1 <= w_new;
        r_count <= r_count + 2'd1;
      end else if (w_pop) begin
        r_slot0 <= r_slot1;
        r_slot1 <= '0;
        r_count <= r_count - 2'd1;
      end

      if (w_push && w_new.selerr && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  assign w_head     = out_valid ? r_slot0 : '0;
  assign out_data   = w_head.data;
  assign out_sel    = w_head.sel;
  assign out_zero   = w_head.zero;
  assign out_neg    = w_head.neg;
  assign out_selerr = w_head.selerr;
  assign count      = r_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: stimulus queues expected entries,
// a negedge monitor checks the head, occupancy and error counter.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_selerr;
  logic [1:0]  count;
  logic [7:0]  err_count;

  alu_result_stage #(.WIDTH(32), .SELW(4), .NSRC(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_selerr (out_selerr),
    .count      (count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        z;
    logic        n;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts just after a posedge; acceptance is decided by in_ready, which has no path from out_ready.
  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] s,
                      input bit z, input bit n, input bit e, input bit rdy);
    bit acc;
    exp_t x;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) begin
      x = '{d: d, s: s, z: z, n: n, e: e};
      q.push_back(x);
      if (e && exp_err != 255) exp_err++;
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("err_count", 64'(err_count), 64'(exp_err));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_head", 64'(out_data), 64'hDEAD);
        end else begin
          chk("head", 64'({out_data, out_sel, out_zero, out_neg, out_selerr}), 64'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end else begin
        chk("empty_outputs", 64'({out_data, out_sel, out_zero, out_neg, out_selerr}), 64'h0);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single result, latency 1, then drained
    step(1, 32'h4, 4'd2, 0, 0, 0, 1);
    chk("lat1_valid", 64'(out_valid), 64'd1);
    chk("lat1_data", 64'(out_data), 64'h4);
    chk("lat1_sel", 64'(out_sel), 64'd2);
    idle(1);
    chk("lat1_drained", 64'(count), 64'd0);

    // Fill to two with backpressure, third refused
    step(1, 32'h1, 4'd1, 0, 0, 0, 0);
    step(1, 32'h2, 4'd1, 0, 0, 0, 0);
    step(1, 32'h8, 4'd1, 0, 0, 0, 0);
    chk("full_count", 64'(count), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_held", 64'(out_data), 64'h1);
    idle(1);
    chk("order_second", 64'(out_data), 64'h2);
    idle(1);
    chk("order_drained", 64'(count), 64'd0);

    // Simultaneous push and pop at count 1
    step(1, 32'h20, 4'd3, 0, 0, 0, 0);
    step(1, 32'h10, 4'd3, 0, 0, 0, 1);
    chk("pushpop_count", 64'(count), 64'd1);
    chk("pushpop_data", 64'(out_data), 64'h10);
    idle(1);

    // Flags and error counting
    step(1, 32'h0, 4'd0, 1, 0, 0, 1);
    chk("zero_flag", 64'(out_zero), 64'd1);
    step(1, 32'h80000000, 4'd4, 0, 1, 0, 1);
    chk("neg_flag", 64'(out_neg), 64'd1);
    step(1, 32'h3, 4'd5, 0, 0, 1, 1);
    chk("selerr_flag", 64'(out_selerr), 64'd1);
    step(1, 32'h3, 4'd6, 0, 0, 1, 1);
    step(1, 32'h3, 4'd7, 0, 0, 1, 1);
    idle(1);
    chk("err_three", 64'(err_count), 64'd3);
    for (int i = 0; i < 300; i++) step(1, 32'h55, 4'd9, 0, 0, 1, 1);
    idle(1);
    chk("err_saturated", 64'(err_count), 64'd255);

    // Asynchronous reset while full
    step(1, 32'hA, 4'd1, 0, 0, 0, 0);
    step(1, 32'hB, 4'd1, 0, 0, 0, 0);
    chk("prerst_count", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    exp_err   = 0;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_push", 64'(count), 64'd0);
    reset = 1'b0;
    step(1, 32'h77, 4'd1, 0, 0, 0, 0);
    chk("post_rst_push", 64'(count), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'h77);
    idle(1);
    idle(1);
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
